// File: rtl/qc_encoder_par_if.sv
// Beat-in / parity-out handshake bundle for the QC-LDPC parallel encoder.
// slave = encoder side, master = producer/consumer side.
interface qc_encoder_par_if #(
    parameter int W = 3,
    parameter int P = 162
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_parity;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_parity
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_parity
    );
endinterface

// File: rtl/qc_encoder_par.sv
// QC-LDPC systematic parity encoder, W info bits per beat; parity valid 1 cycle after the last beat.
// Input stalls (in_ready=0) while finished parity waits for out_ready; parity held stable meanwhile.
module qc_encoder_par #(
    parameter int Z     = 9,
    parameter int K_BLK = 3,
    parameter int M_BLK = 18,
    parameter int W     = 3,
    parameter logic [K_BLK*M_BLK*Z-1:0] G_FIRST = {(K_BLK*M_BLK){{(Z-1){1'b0}}, 1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    qc_encoder_par_if.slave     bus,
    output logic                busy
);
    localparam int K     = K_BLK * Z;
    localparam int P     = M_BLK * Z;
    localparam int BEATS = K / W;
    localparam int BPB   = Z / W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (Z % W != 0) begin : g_bad_w
        $error("qc_encoder_par: Z must be a multiple of W");
    end

    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [P-1:0]  acc_q, acc_d;
    logic [P-1:0]  wrk_q, wrk_d;
    logic [P-1:0]  par_q, par_d;

    logic          in_rdy;
    logic          out_vld;
    logic          accept;
    logic          last_beat;
    int            idx;
    int            blk;
    int            pos;
    logic [P-1:0]  src;
    logic [P-1:0]  acc_sum;

    // Rotate every Z-bit segment independently: bit j takes bit (j-n) mod Z.
    function automatic logic [P-1:0] rot_seg(input logic [P-1:0] v, input int n);
        logic [P-1:0] r;
        r = '0;
        for (int m = 0; m < M_BLK; m++) begin
            for (int j = 0; j < Z; j++) begin
                r[m*Z + j] = v[m*Z + ((j - (n % Z) + Z) % Z)];
            end
        end
        return r;
    endfunction

    function automatic logic [P-1:0] g_blk(input int k);
        return G_FIRST[k*P +: P];
    endfunction

    assign accept = bus.in_valid && in_rdy;

    always_comb begin
        idx       = (state_q == IDLE) ? 0 : int'(cnt_q);
        blk       = idx / BPB;
        pos       = idx % BPB;
        last_beat = (idx == BEATS - 1);
        // Out of reset the working register is zero, so beat 0 reads block 0 directly.
        src       = (state_q == IDLE) ? g_blk(0) : wrk_q;
        acc_sum   = (state_q == IDLE) ? '0 : acc_q;
        for (int w = 0; w < W; w++) begin
            if (bus.in_data[w]) begin
                acc_sum = acc_sum ^ rot_seg(src, w);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        wrk_d = wrk_q;
        par_d = par_q;
        if (accept) begin
            acc_d = acc_sum;
            if (last_beat) begin
                cnt_d = '0;
                par_d = acc_sum;
            end else begin
                cnt_d = CW'(idx + 1);
            end
            if (pos == BPB - 1) begin
                wrk_d = g_blk((blk + 1) % K_BLK);
            end else begin
                wrk_d = rot_seg(src, W);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = last_beat ? OUT : ENC;
            ENC:  if (accept && last_beat) state_d = OUT;
            OUT:  if (out_vld && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = (state_q != OUT);
        out_vld = (state_q == OUT);
        busy    = (state_q == ENC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            wrk_q <= '0;
            par_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            wrk_q <= wrk_d;
            par_q <= par_d;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = out_vld;
    assign bus.out_parity = par_q;
endmodule

// File: tb/tb_qc_encoder_par.sv
// Bench for qc_encoder_par: identity-generator instance for directed cases, pseudo-random
// generator instance for the randomized run; both share the same input stimulus.
module tb_qc_encoder_par;
    localparam int Z     = 9;
    localparam int K_BLK = 3;
    localparam int M_BLK = 18;
    localparam int W     = 3;
    localparam int K     = K_BLK * Z;
    localparam int P     = M_BLK * Z;
    localparam int BEATS = K / W;
    localparam int GW    = K_BLK * M_BLK * Z;

    function automatic logic [GW-1:0] gen_g(input logic [31:0] seed);
        logic [GW-1:0] g;
        logic [31:0]   s;
        g = '0;
        s = seed;
        for (int i = 0; i < GW; i++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            g[i] = s[31];
        end
        return g;
    endfunction

    localparam logic [GW-1:0] G_ID  = {(K_BLK*M_BLK){9'h001}};
    localparam logic [GW-1:0] G_RND = gen_g(32'h1ACE_5EED);

    // GF(2) product straight from the circulant definition.
    function automatic logic [P-1:0] model(input logic [GW-1:0] g, input logic [K-1:0] info);
        logic [P-1:0] p;
        int k, r;
        p = '0;
        for (int i = 0; i < K; i++) begin
            if (info[i]) begin
                k = i / Z;
                r = i % Z;
                for (int m = 0; m < M_BLK; m++) begin
                    for (int j = 0; j < Z; j++) begin
                        p[m*Z + j] = p[m*Z + j] ^ g[(k*M_BLK + m)*Z + ((j - r + Z) % Z)];
                    end
                end
            end
        end
        return p;
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         busy_a, busy_b;
    int           cyc = 0;
    int           last_acc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qc_encoder_par_if #(.W(W), .P(P)) ifa ();
    qc_encoder_par_if #(.W(W), .P(P)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = out_ready;

    qc_encoder_par #(.Z(Z), .K_BLK(K_BLK), .M_BLK(M_BLK), .W(W), .G_FIRST(G_ID)) u_a (
        .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a));
    qc_encoder_par #(.Z(Z), .K_BLK(K_BLK), .M_BLK(M_BLK), .W(W), .G_FIRST(G_RND)) u_b (
        .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b));

    // Present one beat and return #1 after the edge that accepts it.
    task automatic beat(input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (ifa.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: in_ready=%b required 1", ifa.in_ready);
        end
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_cw(input logic [K-1:0] info, input int max_gap);
        int gap;
        for (int b = 0; b < BEATS; b++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            in_valid = 1'b0;
            in_data  = W'($urandom);
            repeat (gap) begin @(posedge clk); #1; end
            beat(info[b*W +: W]);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", ifa.in_ready); end
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", ifa.out_valid); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        n_checks++; if (ifa.out_parity !== '0) begin n_fail++; $display("FAIL rst_parity_a: got %h want 0", ifa.out_parity); end
        n_checks++; if (ifb.out_parity !== '0) begin n_fail++; $display("FAIL rst_parity_b: got %h want 0", ifb.out_parity); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        for (int b = 0; b < BEATS - 1; b++) beat(3'b000);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL zero_busy_enc: got %b want 1", busy_a); end
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_early_valid: got %b want 0", ifa.out_valid); end
        beat(3'b000);
        n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_latency: out_valid=%b want 1", ifa.out_valid); end
        n_checks++; if (ifa.out_parity !== '0) begin n_fail++; $display("FAIL zero_parity: got %h want 0", ifa.out_parity); end
        n_checks++; if (busy_a !== 1'b0 || ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_out_state: busy=%b in_ready=%b want 0 0", busy_a, ifa.in_ready); end
        drain();
        n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_drain: out_valid=%b want 0", ifa.out_valid); end
    endtask

    task automatic test_single_bit();
        logic [P-1:0] e;
        e = {M_BLK{9'h001}};
        send_cw(27'h0000001, 0);
        n_checks++; if (ifa.out_parity !== e) begin n_fail++; $display("FAIL bit0: got %h want %h", ifa.out_parity, e); end
        drain();
        e = {M_BLK{9'h002}};
        send_cw(27'h0000002, 0);
        n_checks++; if (ifa.out_parity !== e) begin n_fail++; $display("FAIL bit1: got %h want %h", ifa.out_parity, e); end
        drain();
    endtask

    task automatic test_cancellation();
        logic [P-1:0] e;
        logic [K-1:0] info;
        info = '0; info[0] = 1'b1; info[9] = 1'b1;
        send_cw(info, 1);
        n_checks++; if (ifa.out_parity !== '0) begin n_fail++; $display("FAIL bits_0_9: got %h want 0", ifa.out_parity); end
        drain();
        e = {M_BLK{9'h003}};
        info = '0; info[0] = 1'b1; info[10] = 1'b1;
        send_cw(info, 1);
        n_checks++; if (ifa.out_parity !== e) begin n_fail++; $display("FAIL bits_0_10: got %h want %h", ifa.out_parity, e); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [K-1:0] info;
        logic [P-1:0] e;
        info = K'($urandom);
        e = model(G_ID, info);
        send_cw(info, 0);
        in_valid = 1'b1;
        in_data  = 3'b111;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", c, ifa.out_valid); end
            n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, ifa.in_ready); end
            n_checks++; if (ifa.out_parity !== e) begin n_fail++; $display("FAIL bp_parity[%0d]: got %h want %h", c, ifa.out_parity, e); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle: out_valid=%b in_ready=%b busy=%b want 0 1 0", ifa.out_valid, ifa.in_ready, busy_a);
        end
        info = K'($urandom);
        e = model(G_ID, info);
        send_cw(info, 0);
        n_checks++; if (ifa.out_parity !== e) begin n_fail++; $display("FAIL bp_next_cw: got %h want %h", ifa.out_parity, e); end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [P-1:0] e;
        for (int b = 0; b < 4; b++) beat(W'($urandom_range(1, 7)));
        @(negedge clk) rst = 1'b1;
        #1;
        n_checks++; if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: out_valid=%b busy=%b want 0 0", ifa.out_valid, busy_a); end
        n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 1", ifa.in_ready); end
        n_checks++; if (ifa.out_parity !== '0 || ifb.out_parity !== '0) begin n_fail++; $display("FAIL mid_rst_parity: a=%h b=%h want 0", ifa.out_parity, ifb.out_parity); end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        send_cw('0, 0);
        n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_parity !== '0) begin n_fail++; $display("FAIL mid_rst_zero: valid=%b parity=%h want 1 0", ifa.out_valid, ifa.out_parity); end
        drain();
        e = {M_BLK{9'h002}};
        send_cw(27'h0000002, 0);
        n_checks++; if (ifa.out_parity !== e) begin n_fail++; $display("FAIL mid_rst_bit1: got %h want %h", ifa.out_parity, e); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [K-1:0] i1, i2;
        int t1;
        i1 = K'($urandom);
        i2 = K'($urandom);
        out_ready = 1'b1;
        send_cw(i1, 0);
        t1 = last_acc;
        n_checks++; if (ifb.out_valid !== 1'b1 || ifb.out_parity !== model(G_RND, i1)) begin
            n_fail++; $display("FAIL b2b_first: valid=%b parity=%h want 1 %h", ifb.out_valid, ifb.out_parity, model(G_RND, i1));
        end
        send_cw(i2, 0);
        n_checks++; if (last_acc - t1 !== BEATS + 1) begin n_fail++; $display("FAIL b2b_period: got %0d want %0d", last_acc - t1, BEATS + 1); end
        n_checks++; if (ifb.out_valid !== 1'b1 || ifb.out_parity !== model(G_RND, i2)) begin
            n_fail++; $display("FAIL b2b_second: valid=%b parity=%h want 1 %h", ifb.out_valid, ifb.out_parity, model(G_RND, i2));
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [K-1:0] info;
        logic [P-1:0] ea, eb;
        int stall;
        for (int n = 0; n < 200; n++) begin
            info = K'({$urandom, $urandom});
            ea = model(G_ID, info);
            eb = model(G_RND, info);
            send_cw(info, 2);
            stall = $urandom_range(0, 3);
            repeat (stall) begin @(posedge clk); #1; end
            n_checks++; if (ifb.out_valid !== 1'b1 || ifb.out_parity !== eb) begin
                n_fail++; $display("FAIL rnd_b[%0d]: valid=%b parity=%h want 1 %h", n, ifb.out_valid, ifb.out_parity, eb);
            end
            n_checks++; if (ifa.out_parity !== ea) begin
                n_fail++; $display("FAIL rnd_a[%0d]: parity=%h want %h", n, ifa.out_parity, ea);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_bit();
        test_cancellation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
